// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, command bytes and frame helpers.
// Also used by the keyboard receiver that sits on the same line pair.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    localparam int FRAME_BITS = 10;

    // LSB-first frame after the start bit: data, odd parity, stop.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 CLK and DATA pins plus CLK falling-edge detect.
// Idle level of both lines is high, so every flop resets to 1.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic clk_meta_q, clk_meta_d;
    logic clk_sync_q, clk_sync_d;
    logic clk_prev_q, clk_prev_d;
    logic data_meta_q, data_meta_d;
    logic data_sync_q, data_sync_d;

    always_comb begin
        clk_meta_d  = ps2_clk;
        clk_sync_d  = clk_meta_q;
        clk_prev_d  = clk_sync_q;
        data_meta_d = ps2_data;
        data_sync_d = data_meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            clk_prev_q  <= clk_prev_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
        end
    end

    assign clk_sync  = clk_sync_q;
    assign data_sync = data_sync_q;
    assign clk_fall  = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, shift on device clock,
// check the device ACK, then wait for bus idle. Lines are driven open-drain via OE pins.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES   = 5000,
    parameter int TIMEOUT_CYCLES   = 750000,
    parameter int IDLE_WAIT_CYCLES = 2500000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iSend,
    input  logic [7:0] iData,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DATA,
    output logic       oPS2_CLK_OE,
    output logic       oPS2_DATA_OE,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError,
    output logic [2:0] oDbgState
);

    localparam int CNT_W = $clog2(max3(INHIBIT_CYCLES, TIMEOUT_CYCLES, IDLE_WAIT_CYCLES));

    // Request handshake: iSend is a one-cycle valid with no ready. It is accepted only
    // while oBusy is low (IDLE); requests seen while busy are dropped, never queued.

    logic clk_sync, data_sync, clk_fall;

    ps2_line_sync u_sync (
        .clk       (Clock),
        .rst       (Reset),
        .ps2_clk   (iPS2_CLK),
        .ps2_data  (iPS2_DATA),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .clk_fall  (clk_fall)
    );

    ps2_state_e            state_q, state_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      tmo_q, tmo_d;
    logic [3:0]            bit_q, bit_d;
    logic                  clk_oe_q, clk_oe_d;
    logic                  data_oe_q, data_oe_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  abort;

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        bit_d     = bit_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        abort     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                if (iSend) begin
                    frame_d = make_frame(iData);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                clk_oe_d = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    data_oe_d = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                // Start bit stays asserted on DATA; releasing CLK hands the clock to the device.
                clk_oe_d = 1'b0;
                tmo_d    = '0;
                bit_d    = '0;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                tmo_d = tmo_q + CNT_W'(1);
                if (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    abort = 1'b1;
                end else if (clk_fall) begin
                    data_oe_d = ~frame_q[0];
                    frame_d   = {1'b1, frame_q[FRAME_BITS-1:1]};
                    bit_d     = bit_q + 4'd1;
                    if (bit_q == 4'(FRAME_BITS - 1)) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                tmo_d = tmo_q + CNT_W'(1);
                if (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    abort = 1'b1;
                end else if (clk_fall) begin
                    if (!data_sync) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (clk_sync && data_sync) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(IDLE_WAIT_CYCLES - 1)) begin
                    abort = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            busy_d    = 1'b0;
            error_d   = 1'b1;
            state_d   = ST_IDLE;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            frame_q   <= '1;
            cnt_q     <= '0;
            tmo_q     <= '0;
            bit_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            bit_q     <= bit_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign oPS2_CLK_OE  = clk_oe_q;
    assign oPS2_DATA_OE = data_oe_q;
    assign oBusy        = busy_q;
    assign oDone        = done_q;
    assign oError       = error_q;
    assign oDbgState    = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model that clocks at a 40-cycle
// period, samples DATA on rising CLK and ACKs on the 11th clock.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send = 1'b0;
    logic [7:0] data = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_pin, ps2_data_pin;
    logic       clk_oe, data_oe, busy, done, err;
    logic [2:0] dbg_state;

    int compared = 0;
    int mismatched = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    assign ps2_clk_pin  = dev_clk & ~clk_oe;
    assign ps2_data_pin = dev_data & ~data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES   (20),
        .TIMEOUT_CYCLES   (2000),
        .IDLE_WAIT_CYCLES (2000)
    ) dut (
        .Clock        (clk),
        .Reset        (rst),
        .iSend        (send),
        .iData        (data),
        .iPS2_CLK     (ps2_clk_pin),
        .iPS2_DATA    (ps2_data_pin),
        .oPS2_CLK_OE  (clk_oe),
        .oPS2_DATA_OE (data_oe),
        .oBusy        (busy),
        .oDone        (done),
        .oError       (err),
        .oDbgState    (dbg_state)
    );

    task automatic tick();
        @(negedge clk);
        if (done) done_cnt++;
        if (err)  err_cnt++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        data = b;
        send = 1'b1;
        tick();
        send = 1'b0;
    endtask

    // Returns how many cycles CLK_OE was high and the DATA level right after release.
    task automatic wait_release(output int hi_len, output logic start_bit);
        int guard;
        guard = 0;
        hi_len = 0;
        while (!clk_oe && guard < 200) begin
            tick();
            guard++;
        end
        while (clk_oe && guard < 400) begin
            hi_len++;
            tick();
            guard++;
        end
        start_bit = ps2_data_pin;
    endtask

    task automatic device(input bit give_ack, input int inject_k, input int reset_k,
                          output logic [9:0] frame);
        frame = '1;
        repeat (10) tick();
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            repeat (20) tick();
            if (k == reset_k) begin
                check("pre_reset_data_oe", 32'(data_oe), 32'd1);
                rst = 1'b1;
                tick();
                check("reset_mid_frame_outputs", {29'd0, clk_oe, data_oe, busy}, 32'd0);
                rst = 1'b0;
                dev_clk = 1'b1;
                return;
            end
            dev_clk = 1'b1;
            if (k <= 10) frame[k-1] = ps2_data_pin;
            if (k == 10 && give_ack) dev_data = 1'b0;
            if (k == 11) dev_data = 1'b1;
            if (k == inject_k) begin
                data = 8'hAA;
                send = 1'b1;
                tick();
                send = 1'b0;
                repeat (19) tick();
            end else begin
                repeat (20) tick();
            end
        end
    endtask

    task automatic wait_not_busy();
        int guard;
        guard = 0;
        while (busy && guard < 3000) begin
            tick();
            guard++;
        end
    endtask

    task automatic full_send(input string tag, input logic [7:0] b, input logic [9:0] exp_frame);
        int hi_len;
        logic start_bit;
        logic [9:0] frame;
        done_cnt = 0;
        err_cnt = 0;
        send_byte(b);
        wait_release(hi_len, start_bit);
        check({tag, "_inhibit_len"}, 32'(hi_len), 32'd20);
        check({tag, "_start_bit"}, 32'(start_bit), 32'd0);
        device(1'b1, 0, 0, frame);
        wait_not_busy();
        check({tag, "_frame"}, 32'(frame), 32'(exp_frame));
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_error_pulses"}, 32'(err_cnt), 32'd0);
        check({tag, "_idle_lines"}, {29'd0, clk_oe, data_oe, busy}, 32'd0);
    endtask

    initial begin
        int hi_len;
        int n;
        logic start_bit;
        logic [9:0] frame;

        // Reset state
        repeat (3) tick();
        check("reset_outputs", {24'd0, dbg_state, clk_oe, data_oe, busy, done, err}, 32'd0);
        rst = 1'b0;
        repeat (5) tick();

        // 1: set-LEDs command, frame {stop 1, parity 1, 0xED}
        full_send("ed", CMD_SET_LEDS, 10'h3ED);

        // 2: enable command (parity 0) and all-zero byte (parity 1)
        full_send("f4", CMD_ENABLE, 10'h2F4);
        full_send("zero", 8'h00, 10'h300);

        // 3: device never clocks -> timeout 2000 cycles after CLK release
        done_cnt = 0;
        err_cnt = 0;
        send_byte(CMD_ENABLE);
        wait_release(hi_len, start_bit);
        n = 0;
        while (err_cnt == 0 && n < 5000) begin
            tick();
            n++;
        end
        check("timeout_cycles", 32'(n), 32'd2000);
        check("timeout_lines", {29'd0, clk_oe, data_oe, busy}, 32'd0);
        repeat (5) tick();
        check("timeout_error_pulses", 32'(err_cnt), 32'd1);
        check("timeout_done_pulses", 32'(done_cnt), 32'd0);
        check("timeout_state_idle", 32'(dbg_state), 32'd0);

        // 4: device omits ACK -> error only; then 0xFF succeeds
        done_cnt = 0;
        err_cnt = 0;
        send_byte(CMD_SET_LEDS);
        wait_release(hi_len, start_bit);
        device(1'b0, 0, 0, frame);
        wait_not_busy();
        check("noack_frame", 32'(frame), 32'h3ED);
        check("noack_error_pulses", 32'(err_cnt), 32'd1);
        check("noack_done_pulses", 32'(done_cnt), 32'd0);
        repeat (10) tick();
        full_send("ff", CMD_RESET, 10'h3FF);

        // 5: iSend of 0xAA during SHIFT is dropped
        done_cnt = 0;
        err_cnt = 0;
        send_byte(8'h3C);
        wait_release(hi_len, start_bit);
        device(1'b1, 4, 0, frame);
        wait_not_busy();
        repeat (100) tick();
        check("ignore_frame", 32'(frame), 32'h33C);
        check("ignore_done_pulses", 32'(done_cnt), 32'd1);
        check("ignore_no_new_frame", {30'd0, clk_oe, busy}, 32'd0);

        // 6: reset while bit 4 is on the line, then a clean resend
        done_cnt = 0;
        err_cnt = 0;
        send_byte(CMD_SET_LEDS);
        wait_release(hi_len, start_bit);
        device(1'b1, 0, 5, frame);
        repeat (50) tick();
        check("reset_no_pulses", 32'(done_cnt + err_cnt), 32'd0);
        check("reset_state_idle", 32'(dbg_state), 32'd0);
        full_send("after_reset", CMD_SET_LEDS, 10'h3ED);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
